// File: rtl/lm75_temp_monitor.sv
// LM75 raw sample -> signed 0.5 degC moving average, hysteretic over-temp alarm, stale-sensor fault.
// Latency 2 cycles from raw_valid to avg_valid; a sample is accepted every cycle, no backpressure.
module lm75_temp_monitor #(
  parameter int AVG_LOG2       = 3,
  parameter int ALARM_HI       = 160,
  parameter int ALARM_HYST     = 10,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_valid,
  input  logic [15:0] raw_temp,
  output logic [31:0] temperature,
  output logic        avg_valid,
  output logic        alarm,
  output logic        fault
);

  localparam int N        = 1 << AVG_LOG2;
  localparam int SW       = 9 + AVG_LOG2;
  localparam int CW       = AVG_LOG2 + 1;
  localparam int WW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ALARM_LO = ALARM_HI - ALARM_HYST;

  localparam logic [CW-1:0]       CNT_LAST = CW'(N - 1);
  localparam logic [WW-1:0]       WD_MAX   = WW'(TIMEOUT_CYCLES);
  localparam logic [AVG_LOG2-1:0] PTR_ONE  = AVG_LOG2'(1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic signed [8:0]      samp;
  logic signed [SW-1:0]   samp_ext;
  logic signed [SW-1:0]   old_ext;
  logic signed [8:0]      smp_buf_q [N];
  logic [AVG_LOG2-1:0]    wptr_q, wptr_d;
  logic [AVG_LOG2-1:0]    wr_idx;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   upd_q, upd_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   fault_q, fault_d;
  logic signed [SW-1:0]   avg_sh;
  logic signed [31:0]     avg_ext;
  logic [31:0]            temp_q, temp_d;
  logic                   avg_vld_q;
  logic                   alarm_q, alarm_d;
  logic                   recover;
  logic                   unused_lsbs;

  // Bits [6:0] of the LM75 register carry no information at 0.5 degC resolution.
  assign samp        = raw_temp[15:7];
  assign unused_lsbs = ^raw_temp[6:0];
  assign samp_ext    = {{AVG_LOG2{samp[8]}}, samp};
  assign old_ext     = {{AVG_LOG2{smp_buf_q[wptr_q][8]}}, smp_buf_q[wptr_q]};
  assign recover     = raw_valid & fault_q;
  assign wr_idx      = recover ? '0 : wptr_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (raw_valid) begin
      if (fault_q) begin
        state_d = S_FILL;
      end else if (state_q == S_FILL && cnt_q == CNT_LAST) begin
        state_d = S_RUN;
      end
    end
  end

  // FSM: stage-1 datapath outputs
  always_comb begin
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    upd_d  = 1'b0;
    if (raw_valid) begin
      if (fault_q) begin
        // A sample after a stale period restarts the window with itself as sample 1.
        sum_d  = samp_ext;
        cnt_d  = CW'(1);
        wptr_d = PTR_ONE;
      end else begin
        wptr_d = wptr_q + PTR_ONE;
        if (state_q == S_FILL) begin
          sum_d = sum_q + samp_ext;
          cnt_d = cnt_q + CW'(1);
          upd_d = (cnt_q == CNT_LAST);
        end else begin
          sum_d = sum_q + samp_ext - old_ext;
          upd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && raw_valid) begin
      smp_buf_q[wr_idx] <= samp;
    end
  end

  // Stage 2: floor average and alarm hysteresis.
  assign avg_sh  = sum_q >>> AVG_LOG2;
  assign avg_ext = {{(32 - SW){avg_sh[SW-1]}}, avg_sh};

  always_comb begin
    temp_d  = temp_q;
    alarm_d = alarm_q;
    if (upd_q) begin
      temp_d = avg_ext;
      if (avg_ext >= ALARM_HI) begin
        alarm_d = 1'b1;
      end else if (avg_ext < ALARM_LO) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (raw_valid) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WW'(1);
    end
    fault_d = (wd_d == WD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      upd_q     <= 1'b0;
      wd_q      <= '0;
      fault_q   <= 1'b0;
      temp_q    <= '0;
      avg_vld_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      upd_q     <= upd_d;
      wd_q      <= wd_d;
      fault_q   <= fault_d;
      temp_q    <= temp_d;
      avg_vld_q <= upd_q;
      alarm_q   <= alarm_d;
    end
  end

  assign temperature = temp_q;
  assign avg_valid   = avg_vld_q;
  assign alarm       = alarm_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_lm75_temp_monitor.sv
// Bench for lm75_temp_monitor: directed vectors, corner sequences and random traffic
// checked every cycle against a sliding-window reference model.
module tb_lm75_temp_monitor;
  localparam int L    = 3;
  localparam int N    = 8;
  localparam int HI   = 160;
  localparam int HYST = 10;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        raw_valid;
  logic [15:0] raw_temp;
  logic [31:0] temperature;
  logic        avg_valid;
  logic        alarm;
  logic        fault;

  lm75_temp_monitor #(
    .AVG_LOG2(L), .ALARM_HI(HI), .ALARM_HYST(HYST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .raw_valid(raw_valid), .raw_temp(raw_temp),
    .temperature(temperature), .avg_valid(avg_valid), .alarm(alarm), .fault(fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: window of the most recent samples since reset / fault recovery.
  int          win[$];
  int          idle     = 0;
  logic        m_fault  = 1'b0;
  logic [31:0] m_temp   = '0;
  logic        m_vld    = 1'b0;
  logic        m_alarm  = 1'b0;
  logic        pend_vld = 1'b0;
  int          pend_avg = 0;

  typedef struct {
    logic [15:0] raw;
    int          reps;
    logic        e_vld;
    logic [31:0] e_temp;
    logic        e_alarm;
  } vec_t;

  vec_t tbl[8];

  function automatic int raw2s(input logic [15:0] r);
    int v;
    v = int'(r[15:7]);
    if (v >= 256) v -= 512;
    return v;
  endfunction

  function automatic int floor_div(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n) != 0 && a < 0) q -= 1;
    return q;
  endfunction

  task automatic model_edge(input logic rst, input logic rv, input logic [15:0] rt);
    int sum;
    if (rst) begin
      win.delete();
      idle     = 0;
      m_fault  = 1'b0;
      m_temp   = '0;
      m_vld    = 1'b0;
      m_alarm  = 1'b0;
      pend_vld = 1'b0;
    end else begin
      m_vld = pend_vld;
      if (pend_vld) begin
        m_temp = pend_avg;
        if (pend_avg >= HI) m_alarm = 1'b1;
        else if (pend_avg < HI - HYST) m_alarm = 1'b0;
      end
      pend_vld = 1'b0;
      if (rv) begin
        if (m_fault) begin
          win.delete();
          m_fault = 1'b0;
        end
        win.push_back(raw2s(rt));
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          pend_avg = floor_div(sum, N);
          pend_vld = 1'b1;
        end
        idle = 0;
      end else begin
        if (idle < TO) idle++;
        m_fault = (idle == TO);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic tick(input logic rst, input logic rv, input logic [15:0] rt);
    reset     = rst;
    raw_valid = rv;
    raw_temp  = rt;
    @(posedge clk);
    model_edge(rst, rv, rt);
    @(negedge clk);
    cyc++;
    chk("model_temperature", temperature, m_temp);
    chk("model_avg_valid", 32'(avg_valid), 32'(m_vld));
    chk("model_alarm", 32'(alarm), 32'(m_alarm));
    chk("model_fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic send(input logic [15:0] rt);
    tick(1'b0, 1'b1, rt);
    tick(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          first;
    logic [31:0] first_temp;
    logic [15:0] r;
    int          mode;

    tbl[0] = '{16'h1900, 7,  1'b0, 32'd0,   1'b0};
    tbl[1] = '{16'h1900, 1,  1'b1, 32'd50,  1'b0};
    tbl[2] = '{16'h1A00, 1,  1'b1, 32'd50,  1'b0};
    tbl[3] = '{16'h1A00, 15, 1'b1, 32'd52,  1'b0};
    tbl[4] = '{16'h5000, 8,  1'b1, 32'd160, 1'b1};
    tbl[5] = '{16'h4C00, 8,  1'b1, 32'd152, 1'b1};
    tbl[6] = '{16'h4800, 2,  1'b1, 32'd150, 1'b1};
    tbl[7] = '{16'h4800, 1,  1'b1, 32'd149, 1'b0};

    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 16'h1900);
    chk("reset_temperature", temperature, 32'd0);
    chk("reset_avg_valid", 32'(avg_valid), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);

    foreach (tbl[k]) begin
      for (int r2 = 0; r2 < tbl[k].reps; r2++) send(tbl[k].raw);
      chk($sformatf("tbl%0d_avg_valid", k), 32'(avg_valid), 32'(tbl[k].e_vld));
      chk($sformatf("tbl%0d_temperature", k), temperature, tbl[k].e_temp);
      chk($sformatf("tbl%0d_alarm", k), 32'(alarm), 32'(tbl[k].e_alarm));
    end

    // Watchdog: one idle cycle already elapsed after the last sample.
    for (int i = 0; i < 98; i++) tick(1'b0, 1'b0, 16'h0000);
    chk("wd_fault_at_99", 32'(fault), 32'd0);
    tick(1'b0, 1'b0, 16'h0000);
    chk("wd_fault_at_100", 32'(fault), 32'd1);
    tick(1'b0, 1'b1, 16'h1900);
    chk("wd_recover_fault", 32'(fault), 32'd0);
    tick(1'b0, 1'b0, 16'h0000);
    chk("wd_refill_vld1", 32'(avg_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      send(16'h1900);
      chk("wd_refill_vld", 32'(avg_valid), 32'd0);
    end
    chk("wd_refill_temp_hold", temperature, 32'd149);
    send(16'h1900);
    chk("wd_refill_8th_vld", 32'(avg_valid), 32'd1);
    chk("wd_refill_8th_temp", temperature, 32'd50);
    for (int i = 0; i < 98; i++) tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 16'h1900);
    chk("wd_strobe_wins", 32'(fault), 32'd0);
    for (int i = 0; i < 99; i++) tick(1'b0, 1'b0, 16'h0000);
    chk("wd_rearm_99", 32'(fault), 32'd0);
    tick(1'b0, 1'b0, 16'h0000);
    chk("wd_rearm_100", 32'(fault), 32'd1);

    // Negative average rounds toward minus infinity.
    tick(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      send(16'hFF80);
      send(16'h0000);
    end
    chk("neg_avg_valid", 32'(avg_valid), 32'd1);
    chk("neg_temperature", temperature, 32'hFFFF_FFFF);
    chk("neg_alarm", 32'(alarm), 32'd0);

    // Back-to-back samples with a reset landing on sample 5.
    first      = -1;
    first_temp = '0;
    for (int i = 0; i < 20; i++) begin
      tick(i == 4, 1'b1, (i < 4) ? 16'h1000 : 16'h2000);
      if (i == 4) begin
        chk("midrst_temperature", temperature, 32'd0);
        chk("midrst_avg_valid", 32'(avg_valid), 32'd0);
      end
      if (i > 4 && avg_valid === 1'b1 && first < 0) begin
        first      = i;
        first_temp = temperature;
      end
    end
    chk("midrst_first_vld_cycle", 32'(first), 32'd13);
    chk("midrst_first_temp", first_temp, 32'd64);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);

    // Random traffic against the model.
    tick(1'b1, 1'b0, 16'h0000);
    for (int seg = 0; seg < 24; seg++) begin
      mode = int'($urandom_range(0, 4));
      if (mode == 2) begin
        for (int i = 0; i < 110; i++) tick(1'b0, 1'b0, 16'h0000);
      end else begin
        for (int i = 0; i < 40; i++) begin
          r = 16'($urandom);
          if (mode == 1) r[15:7] = 9'(140 + $urandom_range(0, 35));
          if (mode == 3) r[15:7] = 9'(120 + $urandom_range(0, 30));
          tick((mode == 4) && ($urandom_range(0, 39) == 0),
               (mode == 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1), r);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
